serial_to_parallel: RTL and testbench
=====================================

Name: serial_to_parallel

Overview:
- Receive-side deserializer for the single-bit framed stream produced by the team's parallel-to-serial shifter.
- A frame is exactly N consecutive cycles of i_valid high, MSB first, followed by at least one cycle of i_valid low.
- The block checks framing, assembles the N-bit word and presents it on a valid/ready output register.
- It flags short frames, long frames and output overrun.

Parameters:
- N, default 8, word width and frame length in bits; N >= 2 required.

Ports:
- i_clock  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  receiver enable; low aborts any frame in progress
- i_valid  in  1  serial bit valid (frame envelope)
- i_data  in  1  serial data bit, MSB first
- i_ready  in  1  downstream accepts o_data when o_valid=1
- o_valid  out  1  o_data holds an unconsumed word
- o_data  out  N  received word, bit N-1 = first serial bit
- o_err_short  out  1  1-cycle pulse: frame ended before N bits
- o_err_long  out  1  1-cycle pulse: i_valid still high after N bits
- o_overrun  out  1  1-cycle pulse: good frame dropped because output full

Behaviour:
- Reset (i_reset=1 at clock edge) clears everything: FSM=IDLE, shift reg=0, bit counter=0, o_valid=0, o_data=0, all pulse outputs=0. Reset overrides i_enable and mid-frame state.
- Pulse outputs default to 0 every cycle unless set below.
- FSM states: IDLE, SHIFT, CHECK, DISCARD. Counter width = ceil(log2(N)).
- IDLE:
  - i_valid=1: shift in i_data as the first bit, cnt<=1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - i_valid=1: shift reg <= {shift[N-2:0], i_data}, cnt++. If cnt was N-1 (Nth bit taken), go to CHECK.
  - i_valid=0: pulse o_err_short, discard partial word, cnt<=0, go to IDLE.
- CHECK (N bits held, waiting for the gap):
  - i_valid=0: commit the word (see output rules), go to IDLE.
  - i_valid=1: pulse o_err_long, discard the word, go to DISCARD.
- DISCARD:
  - Stay while i_valid=1.
  - i_valid=0: go to IDLE. No further pulses.
- Latency: the last data bit is sampled at edge k, the gap is sampled at edge k+1, and o_valid=1 and o_data are visible after edge k+1.
- Minimum frame spacing is one idle cycle. A new frame's first bit can be sampled at the edge immediately after the commit edge.
- Output register rules:
  - Consume: o_valid & i_ready at an edge clears o_valid. o_data holds its last value.
  - Commit with o_valid=0: o_data<=word, o_valid<=1.
  - Commit with o_valid=1 and i_ready=1 on the same edge: load the new word, o_valid stays 1, no overrun.
  - Commit with o_valid=1 and i_ready=0: drop the new word, pulse o_overrun. o_data and o_valid are unchanged.
- Errors never affect o_valid or o_data.
- i_enable=0 (and no reset):
  - FSM to IDLE, cnt<=0, partial or checked word discarded, o_valid<=0, no error pulses.
  - o_data and the shift reg retain their values.
  - If i_valid is still high when i_enable returns, the remainder of that frame is received as a fresh frame and ends as short or long. This is accepted behaviour.
- i_data is ignored whenever i_valid=0.

Optional Feature:
- Macro: SERIAL_TO_PARALLEL_ERRCNT_EN.
- Defined:
  - Adds output o_err_count[7:0], a saturating count of o_err_short + o_err_long + o_overrun events.
  - Increments by 1 per cycle in which any of the three pulses is set.
  - Holds at 255.
  - Cleared by reset only; i_enable has no effect on it.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- N=8, i_ready=1, frame 0xA5 (bits 1,0,1,0,0,1,0,1) then 1 idle cycle -> o_valid=1 with o_data=0xA5 for exactly 1 cycle after the gap edge; no error pulses.
- Back-to-back frames 0x3C, 0xC3 separated by 1 idle cycle, i_ready=1 -> two consecutive words 0x3C then 0xC3, each o_valid for 1 cycle.
- 5-bit frame then gap -> o_err_short pulse 1 cycle after the gap is sampled; o_valid stays 0. Next full frame 0x0F is received correctly.
- 10-bit burst -> o_err_long pulses once, at the edge sampling the 9th bit; no word committed; following frame 0xF0 received OK.
- i_ready=0, frames 0x11 then 0x22 -> o_data=0x11 held, o_overrun pulses at the 0x22 commit. Then i_ready=1 -> 0x11 consumed, o_valid=0. With the macro defined, o_err_count=1.
- Deassert i_enable after bit 4 of a frame, re-enable with i_valid low -> no word, no error pulse. Assert i_reset mid-frame -> all outputs 0, next frame 0x81 received correctly.

Source files
------------

// File: rtl/serial_to_parallel_if.sv
// serial_to_parallel_if
//   Bundles the serial input side, the valid/ready word output and the error
//   pulses of serial_to_parallel. Clock and reset stay as plain module ports.
//   slave  : the deserializer (drives o_*, reads i_*)
//   master : the stream source / word consumer (drives i_*, reads o_*)
//   Optional SERIAL_TO_PARALLEL_ERRCNT_EN adds o_err_count[7:0].
interface serial_to_parallel_if #(
  parameter int N = 8
);
  logic         i_enable;
  logic         i_valid;
  logic         i_data;
  logic         i_ready;
  logic         o_valid;
  logic [N-1:0] o_data;
  logic         o_err_short;
  logic         o_err_long;
  logic         o_overrun;
`ifdef SERIAL_TO_PARALLEL_ERRCNT_EN
  logic [7:0]   o_err_count;

  modport slave (
    input  i_enable, i_valid, i_data, i_ready,
    output o_valid, o_data, o_err_short, o_err_long, o_overrun, o_err_count
  );
  modport master (
    output i_enable, i_valid, i_data, i_ready,
    input  o_valid, o_data, o_err_short, o_err_long, o_overrun, o_err_count
  );
`else
  modport slave (
    input  i_enable, i_valid, i_data, i_ready,
    output o_valid, o_data, o_err_short, o_err_long, o_overrun
  );
  modport master (
    output i_enable, i_valid, i_data, i_ready,
    input  o_valid, o_data, o_err_short, o_err_long, o_overrun
  );
`endif
endinterface

// File: rtl/serial_to_parallel.sv
// serial_to_parallel
//   Deserializer for the framed single-bit stream: a frame is exactly N cycles
//   of i_valid high (MSB first) followed by at least one idle cycle. The
//   assembled word is presented on a valid/ready output register; short
//   frames, long frames and output overruns raise 1-cycle pulses.
//
//   Ports:
//     i_clock      clock, rising edge
//     i_reset      synchronous, active-high reset
//     bus (slave)  i_enable, i_valid, i_data, i_ready in;
//                  o_valid, o_data[N-1:0], o_err_short, o_err_long, o_overrun out
//
//   Optional: define SERIAL_TO_PARALLEL_ERRCNT_EN to add bus.o_err_count[7:0],
//   a saturating count of cycles carrying any error/overrun pulse.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | between frames, first valid bit starts a new frame
//   SHIFT   | collecting bits 2..N of a frame
//   CHECK   | N bits held, next cycle must be the gap to commit
//   DISCARD | frame overran N bits, waiting for the gap
module serial_to_parallel #(
  parameter int N = 8
) (
  input logic            i_clock,
  input logic            i_reset,
  serial_to_parallel_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  data_q, data_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic          overrun_q, overrun_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    data_d      = data_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && bus.i_ready)
      valid_d = 1'b0;

    if (!bus.i_enable) begin
      // Abort: drop any frame and the pending word, keep o_data/shift as-is.
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            shift_d = {shift_q[N-2:0], bus.i_data};
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (bus.i_valid) begin
            shift_d = {shift_q[N-2:0], bus.i_data};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT)
              state_d = CHECK;
          end else begin
            err_short_d = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
          end
        end
        CHECK: begin
          cnt_d = '0;
          if (!bus.i_valid) begin
            state_d = IDLE;
            // A word consumed on this same edge frees the register for the new one.
            if (!valid_q || bus.i_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            err_long_d = 1'b1;
            state_d    = DISCARD;
          end
        end
        DISCARD: begin
          if (!bus.i_valid)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_data      = data_q;
  assign bus.o_err_short = err_short_q;
  assign bus.o_err_long  = err_long_q;
  assign bus.o_overrun   = overrun_q;

`ifdef SERIAL_TO_PARALLEL_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counts on the edge that raises a pulse, so it moves together with the pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset)
      err_cnt_q <= '0;
    else if ((err_short_d || err_long_d || overrun_d) && (err_cnt_q != 8'hFF))
      err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign bus.o_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
module tb_serial_to_parallel;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_to_parallel_if #(.N(N)) bus();

  serial_to_parallel #(.N(N)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // pulse counts observed since last cleared
  int p_short, p_long, p_ovr;

  // behavioural reference: run length of the current frame plus an
  // arithmetic word accumulator
  int       m_run = 0;
  int       m_word = 0;
  bit       m_valid = 0;
  bit [7:0] m_data = 0;
  bit       m_short = 0, m_long = 0, m_ovr = 0;
  int       m_cnt = 0;

  typedef struct {
    int          len;
    logic [15:0] bits;
    bit          rdy;
    bit          flush;
    bit          exp_valid;
    logic [7:0]  exp_data;
    int          exp_short;
    int          exp_long;
    int          exp_ovr;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit en, input bit v, input bit d, input bit rdy);
    bit prev_valid;
    if (r) begin
      m_run = 0; m_word = 0; m_valid = 0; m_data = 0;
      m_short = 0; m_long = 0; m_ovr = 0; m_cnt = 0;
      return;
    end
    m_short = 0; m_long = 0; m_ovr = 0;
    if (!en) begin
      m_run = 0;
      m_valid = 0;
    end else begin
      prev_valid = m_valid;
      if (m_valid && rdy) m_valid = 0;
      if (v) begin
        if (m_run < N) begin
          m_word = (m_word * 2 + int'(d)) % (1 << N);
          m_run++;
        end else if (m_run == N) begin
          m_long = 1;
          m_run = N + 1;
        end
      end else begin
        if (m_run > 0 && m_run < N) m_short = 1;
        if (m_run == N) begin
          if (!prev_valid || rdy) begin
            m_data = 8'(m_word);
            m_valid = 1;
          end else begin
            m_ovr = 1;
          end
        end
        m_run = 0;
      end
    end
    if ((m_short || m_long || m_ovr) && m_cnt < 255) m_cnt++;
  endtask

  task automatic step(input bit r, input bit en, input bit v, input bit d, input bit rdy);
    rst = r;
    bus.i_enable = en;
    bus.i_valid = v;
    bus.i_data = d;
    bus.i_ready = rdy;
    @(posedge clk);
    model_update(r, en, v, d, rdy);
    #1;
    chk("model", 32'({bus.o_valid, bus.o_data, bus.o_err_short, bus.o_err_long, bus.o_overrun}),
        32'({m_valid, m_data, m_short, m_long, m_ovr}));
`ifdef SERIAL_TO_PARALLEL_ERRCNT_EN
    chk("model_errcnt", 32'(bus.o_err_count), 32'(m_cnt));
`endif
    p_short += int'(bus.o_err_short);
    p_long  += int'(bus.o_err_long);
    p_ovr   += int'(bus.o_overrun);
  endtask

  task automatic send(input int len, input logic [15:0] bits, input bit rdy);
    for (int i = len - 1; i >= 0; i--)
      step(0, 1, 1, bits[i], rdy);
    step(0, 1, 0, 1'($urandom_range(0, 1)), rdy);
  endtask

  task automatic clr_pulses();
    p_short = 0; p_long = 0; p_ovr = 0;
  endtask

  initial begin
    int len, g;
    bit en, rdy;

    tbl[0]  = '{8,  16'h00A5, 1, 0, 1, 8'hA5, 0, 0, 0};
    tbl[1]  = '{8,  16'h003C, 1, 0, 1, 8'h3C, 0, 0, 0};
    tbl[2]  = '{8,  16'h00C3, 1, 0, 1, 8'hC3, 0, 0, 0};
    tbl[3]  = '{5,  16'h0016, 1, 0, 0, 8'hC3, 1, 0, 0};
    tbl[4]  = '{8,  16'h000F, 1, 0, 1, 8'h0F, 0, 0, 0};
    tbl[5]  = '{10, 16'h03FF, 1, 0, 0, 8'h0F, 0, 1, 0};
    tbl[6]  = '{8,  16'h00F0, 1, 0, 1, 8'hF0, 0, 0, 0};
    tbl[7]  = '{7,  16'h0055, 1, 0, 0, 8'hF0, 1, 0, 0};
    tbl[8]  = '{9,  16'h01AA, 1, 0, 0, 8'hF0, 0, 1, 0};
    tbl[9]  = '{8,  16'h007E, 1, 0, 1, 8'h7E, 0, 0, 0};
    tbl[10] = '{8,  16'h0011, 0, 1, 1, 8'h11, 0, 0, 0};
    tbl[11] = '{8,  16'h0022, 0, 0, 1, 8'h11, 0, 0, 1};

    clr_pulses();
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("reset_outputs", 32'({bus.o_valid, bus.o_data, bus.o_err_short, bus.o_err_long, bus.o_overrun}), 32'd0);

    foreach (tbl[i]) begin
      if (tbl[i].flush) step(0, 1, 0, 0, 1);
      clr_pulses();
      send(tbl[i].len, tbl[i].bits, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), 32'(bus.o_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_data", i), 32'(bus.o_data), 32'(tbl[i].exp_data));
      chk($sformatf("vec%0d_short", i), 32'(p_short), 32'(tbl[i].exp_short));
      chk($sformatf("vec%0d_long", i), 32'(p_long), 32'(tbl[i].exp_long));
      chk($sformatf("vec%0d_ovr", i), 32'(p_ovr), 32'(tbl[i].exp_ovr));
    end

    // held word consumed once ready returns
    step(0, 1, 0, 0, 1);
    chk("consume_valid", 32'(bus.o_valid), 32'd0);
    chk("consume_data", 32'(bus.o_data), 32'h11);
`ifdef SERIAL_TO_PARALLEL_ERRCNT_EN
    chk("errcnt_after_table", 32'(bus.o_err_count), 32'd5);
`endif

    // enable dropped after 4 bits, re-enabled with i_valid low
    clr_pulses();
    step(0, 1, 1, 1, 1); step(0, 1, 1, 0, 1); step(0, 1, 1, 1, 1); step(0, 1, 1, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    chk("abort_valid", 32'(bus.o_valid), 32'd0);
    chk("abort_pulses", 32'(p_short + p_long + p_ovr), 32'd0);
    send(8, 16'h005A, 0);
    chk("after_abort_data", 32'({bus.o_valid, bus.o_data}), 32'h15A);
    step(0, 0, 0, 0, 0);
    chk("disable_clears_valid", 32'({bus.o_valid, bus.o_data}), 32'h05A);

    // reset mid-frame
    step(0, 1, 1, 1, 1); step(0, 1, 1, 1, 1); step(0, 1, 1, 0, 1);
    step(1, 1, 1, 1, 1);
    chk("midframe_reset", 32'({bus.o_valid, bus.o_data, bus.o_err_short, bus.o_err_long, bus.o_overrun}), 32'd0);
`ifdef SERIAL_TO_PARALLEL_ERRCNT_EN
    chk("reset_errcnt", 32'(bus.o_err_count), 32'd0);
`endif
    clr_pulses();
    send(8, 16'h0081, 1);
    chk("after_reset_data", 32'({bus.o_valid, bus.o_data}), 32'h181);
    chk("after_reset_pulses", 32'(p_short + p_long + p_ovr), 32'd0);

`ifdef SERIAL_TO_PARALLEL_ERRCNT_EN
    for (int i = 0; i < 260; i++) send(1, 16'h0001, 1);
    chk("errcnt_saturate", 32'(bus.o_err_count), 32'd255);
`endif

    // randomized frames against the reference model
    for (int f = 0; f < 400; f++) begin
      len = ($urandom_range(0, 9) < 6) ? N : int'($urandom_range(1, 11));
      for (int b = 0; b < len; b++) begin
        en  = ($urandom_range(0, 59) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        step(($urandom_range(0, 299) == 0), en, 1, 1'($urandom_range(0, 1)), rdy);
      end
      g = int'($urandom_range(1, 3));
      for (int k = 0; k < g; k++) begin
        en  = ($urandom_range(0, 59) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        step(0, en, 0, 1'($urandom_range(0, 1)), rdy);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
